// File: rtl/demux_pkg.sv
// Shared types for the 4-way dispatcher: FSM state, destination index and
// the one-hot destination decode used for the per-destination valids.
package demux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef logic [1:0] dest_t;

    function automatic logic [3:0] dest_dec(input dest_t d);
        logic [3:0] r_oneHot;
        r_oneHot = 4'b0000;
        r_oneHot[d] = 1'b1;
        return r_oneHot;
    endfunction

endpackage

// File: rtl/dispatch_valid_demux.sv
// 1-to-4 demux of the internal "word held" bit onto the destination valids,
// steered by the held word's destination index.
module dispatch_valid_demux
    import demux_pkg::*;
(
    input  logic       i_valid,
    input  dest_t      i_sel,
    output logic [3:0] o_valid
);

    assign o_valid = i_valid ? dest_dec(i_sel) : 4'b0000;

endmodule

// File: rtl/demux4_dispatcher.sv
// Holds one producer word and routes it to one of four consumers, either
// round-robin (skipping a consumer that stalls too long) or to a fixed index.
module demux4_dispatcher
    import demux_pkg::*;
#(
    parameter int W         = 8,
    parameter int STALL_MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         mode,
    input  logic [1:0]   cfg_sel,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   sel,
    output logic         busy
);

    // A zero threshold still needs a legal one-bit counter.
    localparam int            CW        = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
    localparam logic [CW-1:0] STALL_LIM = CW'(STALL_MAX);
    localparam logic          REDIR_EN  = (STALL_MAX != 0);

    state_t        r_state;
    dest_t         r_sel;
    dest_t         r_rrPtr;
    logic [CW-1:0] r_stallCnt;
    logic [W-1:0]  r_data;

    logic  w_sending;
    logic  w_readySel;
    logic  w_accept;
    logic  w_complete;
    logic  w_redirect;
    dest_t w_rrNext;
    dest_t w_newSel;

    assign w_sending  = (r_state == SEND);
    assign w_readySel = out_ready[r_sel];
    assign in_ready   = en & (~w_sending | w_readySel);
    assign w_accept   = in_valid & in_ready;
    assign w_complete = w_sending & w_readySel;
    assign w_redirect = w_sending & ~mode & REDIR_EN & ~w_readySel
                        & (r_stallCnt == STALL_LIM);

    // A completion in the same cycle as an accept must already see the
    // advanced pointer, otherwise back-to-back words would repeat a slot.
    assign w_rrNext = (w_complete & ~mode) ? dest_t'(r_sel + 2'd1) : r_rrPtr;
    assign w_newSel = mode ? dest_t'(cfg_sel) : w_rrNext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_data  <= '0;
        end else if (w_accept) begin
            r_state <= SEND;
            r_sel   <= w_newSel;
            r_data  <= in_data;
        end else if (w_complete) begin
            r_state <= IDLE;
        end else if (w_redirect) begin
            r_sel <= dest_t'(r_sel + 2'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrPtr <= 2'd0;
        end else if (w_redirect) begin
            r_rrPtr <= dest_t'(r_sel + 2'd2);
        end else begin
            r_rrPtr <= w_rrNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (w_complete | w_redirect) begin
            r_stallCnt <= '0;
        end else if (w_sending) begin
            r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    dispatch_valid_demux u_validDemux (
        .i_valid (w_sending),
        .i_sel   (r_sel),
        .o_valid (out_valid)
    );

    assign out_data = r_data;
    assign sel      = r_sel;
    assign busy     = w_sending;

endmodule

// File: tb/tb_demux4_dispatcher.sv
// Directed bench for demux4_dispatcher: two instances share stimulus, one with
// the default stall threshold and one with a short threshold for redirects.
module tb_demux4_dispatcher;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [1:0] cfgSel;
    logic       inValid;
    logic [7:0] inData;
    logic [3:0] outReady;

    logic       aInReady, bInReady;
    logic [3:0] aOutValid, bOutValid;
    logic [7:0] aOutData, bOutData;
    logic [1:0] aSel, bSel;
    logic       aBusy, bBusy;

    int checks;
    int failures;

    demux4_dispatcher #(.W(8), .STALL_MAX(15)) dutA (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .cfg_sel   (cfgSel),
        .in_valid  (inValid),
        .in_ready  (aInReady),
        .in_data   (inData),
        .out_valid (aOutValid),
        .out_ready (outReady),
        .out_data  (aOutData),
        .sel       (aSel),
        .busy      (aBusy)
    );

    demux4_dispatcher #(.W(8), .STALL_MAX(3)) dutB (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .cfg_sel   (cfgSel),
        .in_valid  (inValid),
        .in_ready  (bInReady),
        .in_data   (inData),
        .out_valid (bOutValid),
        .out_ready (outReady),
        .out_data  (bOutData),
        .sel       (bSel),
        .busy      (bBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n   = 1'b0;
        inValid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [1:0] rrSeq [6];
        rrSeq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        checks   = 0;
        failures = 0;
        en       = 1'b1;
        mode     = 1'b0;
        cfgSel   = 2'd0;
        inValid  = 1'b0;
        inData   = 8'h00;
        outReady = 4'b0000;
        rst_n    = 1'b0;
        #12;

        // Reset state
        checkOutput("rst_out_valid", aOutValid, 4'b0000);
        checkOutput("rst_sel", aSel, 2'd0);
        checkOutput("rst_busy", aBusy, 1'b0);
        checkOutput("rst_in_ready", aInReady, 1'b1);
        checkOutput("rst_out_data", aOutData, 8'h00);
        applyReset();

        // Round-robin streaming, one word per cycle
        outReady = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            inValid = 1'b1;
            inData  = 8'h10 + 8'(i);
            #1;
            checkOutput($sformatf("rr_in_ready_%0d", i), aInReady, 1'b1);
            tick();
            checkOutput($sformatf("rr_sel_%0d", i), aSel, rrSeq[i]);
            checkOutput($sformatf("rr_valid_%0d", i), aOutValid, 4'b0001 << rrSeq[i]);
            checkOutput($sformatf("rr_data_%0d", i), aOutData, 8'h10 + 8'(i));
        end
        inValid = 1'b0;
        tick();
        checkOutput("rr_drain_busy", aBusy, 1'b0);

        // Fixed mode to destination 2
        applyReset();
        mode     = 1'b1;
        cfgSel   = 2'd2;
        outReady = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            inValid = 1'b1;
            inData  = 8'hC0 + 8'(i);
            tick();
            checkOutput($sformatf("fix_valid_%0d", i), aOutValid, 4'b0100);
            checkOutput($sformatf("fix_data_%0d", i), aOutData, 8'hC0 + 8'(i));
        end
        inValid = 1'b0;
        tick();
        checkOutput("fix_drain_busy", aBusy, 1'b0);
        outReady = 4'b0000;
        inValid  = 1'b1;
        inData   = 8'hC3;
        tick();
        inValid = 1'b0;
        cfgSel  = 2'd1;
        tick();
        checkOutput("fix_cfgchg_sel", aSel, 2'd2);
        checkOutput("fix_cfgchg_valid", aOutValid, 4'b0100);
        outReady = 4'b0010;
        tick();
        checkOutput("fix_other_ready_busy", aBusy, 1'b1);
        checkOutput("fix_other_ready_sel", aSel, 2'd2);
        outReady = 4'b0100;
        tick();
        checkOutput("fix_cfgchg_done", aBusy, 1'b0);

        // Backpressure on destination 0
        applyReset();
        mode     = 1'b0;
        outReady = 4'b1110;
        inValid  = 1'b1;
        inData   = 8'hA5;
        tick();
        inData = 8'h77;
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_in_ready_%0d", k), aInReady, 1'b0);
            checkOutput($sformatf("bp_data_%0d", k), aOutData, 8'hA5);
            checkOutput($sformatf("bp_valid_%0d", k), aOutValid, 4'b0001);
            tick();
        end
        outReady = 4'b1111;
        #1;
        checkOutput("bp_release_ready", aInReady, 1'b1);
        tick();
        checkOutput("bp_next_sel", aSel, 2'd1);
        checkOutput("bp_next_data", aOutData, 8'h77);
        inValid = 1'b0;
        tick();
        checkOutput("bp_drain_busy", aBusy, 1'b0);

        // Redirect with short threshold
        applyReset();
        mode     = 1'b0;
        outReady = 4'b1110;
        inValid  = 1'b1;
        inData   = 8'h5A;
        tick();
        inValid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("redir_hold_sel_%0d", k), bSel, 2'd0);
            tick();
        end
        checkOutput("redir_sel", bSel, 2'd1);
        checkOutput("redir_valid", bOutValid, 4'b0010);
        checkOutput("redir_data", bOutData, 8'h5A);
        inValid = 1'b1;
        inData  = 8'h6B;
        tick();
        checkOutput("redir_next_sel", bSel, 2'd2);
        checkOutput("redir_next_data", bOutData, 8'h6B);
        inValid = 1'b0;
        tick();
        checkOutput("redir_drain_busy", bBusy, 1'b0);

        // Same stall in fixed mode never redirects
        applyReset();
        mode     = 1'b1;
        cfgSel   = 2'd0;
        outReady = 4'b1110;
        inValid  = 1'b1;
        inData   = 8'h5A;
        tick();
        inValid = 1'b0;
        repeat (6) tick();
        checkOutput("fixstall_sel", bSel, 2'd0);
        checkOutput("fixstall_valid", bOutValid, 4'b0001);
        outReady = 4'b1111;
        tick();
        checkOutput("fixstall_done", bBusy, 1'b0);

        // Enable dropped while a word is held
        applyReset();
        mode     = 1'b0;
        outReady = 4'b0000;
        inValid  = 1'b1;
        inData   = 8'h33;
        tick();
        en     = 1'b0;
        inData = 8'h44;
        #1;
        checkOutput("en_off_ready_stall", aInReady, 1'b0);
        outReady = 4'b1111;
        #1;
        checkOutput("en_off_ready_open", aInReady, 1'b0);
        tick();
        checkOutput("en_off_done_busy", aBusy, 1'b0);
        checkOutput("en_off_done_valid", aOutValid, 4'b0000);
        tick();
        checkOutput("en_off_idle_ready", aInReady, 1'b0);
        checkOutput("en_off_idle_busy", aBusy, 1'b0);
        en = 1'b1;
        #1;
        checkOutput("en_on_ready", aInReady, 1'b1);
        tick();
        checkOutput("en_on_sel", aSel, 2'd1);
        checkOutput("en_on_data", aOutData, 8'h44);
        inValid = 1'b0;
        tick();

        // Asynchronous reset while a word is held
        applyReset();
        outReady = 4'b0000;
        inValid  = 1'b1;
        inData   = 8'h99;
        tick();
        inValid = 1'b0;
        checkOutput("arst_pre_busy", aBusy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", aOutValid, 4'b0000);
        checkOutput("arst_busy", aBusy, 1'b0);
        checkOutput("arst_data", aOutData, 8'h00);
        outReady = 4'b1111;
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("arst_after_valid", aOutValid, 4'b0000);
        checkOutput("arst_after_busy", aBusy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux4_dispatcher.md
# demux4_dispatcher

Sequencing controller for the 1-to-4 demultiplexer datapath. Accepts a stream of words over a valid/ready handshake, holds one word, and routes it to one of four destinations over per-destination valid/ready pairs. Destinations are chosen round-robin or by a fixed configured select. In round-robin mode, a destination that stalls too long is skipped. Sits between a single producer and four consumers sharing one data bus.

## Interface
- W, 8, data width
- STALL_MAX, 15, round-robin redirect threshold in stall cycles; 0 disables redirect

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  dispatch enable; gates new accepts only
- mode  in  1  0 = round-robin, 1 = fixed destination cfg_sel
- cfg_sel  in  2  fixed-mode destination index
- in_valid  in  1  producer word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  W  producer word
- out_valid  out  4  one-hot destination valid; all-zero when nothing held
- out_ready  in  4  per-destination ready
- out_data  out  W  held word, shared by all destinations
- sel  out  2  destination index of the held word
- busy  out  1  a word is held

## Operation
- States: IDLE (nothing held) and SEND (word held in a register).
- in_ready = en & (state==IDLE | (state==SEND & out_ready[sel])).
  - Accept occurs when in_valid & in_ready.
- Destination is latched into sel at accept:
  - mode=1: sel = cfg_sel.
  - mode=0: sel = rr_ptr.
- rr_ptr:
  - Advances to sel+1 (mod 4, 3 wraps to 0) on every completed transfer in mode 0.
  - Unchanged in mode 1.
- In SEND, out_valid = one-hot decode of sel; out_data = held word.
- Completion occurs when out_valid[sel] & out_ready[sel]:
  - With a simultaneous accept, stay in SEND and load the new word and sel. Throughput is 1 word/cycle.
  - Otherwise go to IDLE.
- stall_cnt:
  - Width $clog2(STALL_MAX+1).
  - Increments each SEND cycle with out_ready[sel]=0.
  - Clears on completion and on redirect.
- Redirect applies only when mode=0, STALL_MAX≠0, and stall_cnt==STALL_MAX with out_ready[sel]=0 still low:
  - sel ← sel+1 mod 4 and rr_ptr ← sel+2 mod 4.
  - Held word is retained.
  - No word is ever dropped.
- The held word's sel is unaffected by mode/cfg_sel changes during SEND; it is only redirected as above.
- en deasserted during SEND: the current word still completes, and no new accept happens.
- out_ready bits other than sel are ignored.
- busy = (state==SEND).

## Timing
- Reset (async assert, synchronous release) gives:
  - state IDLE
  - sel=0, rr_ptr=0, stall_cnt=0
  - out_valid=4'b0000
  - out_data=0
  - busy=0
  - in_ready=en
- Reset mid-SEND discards the held word.
- Latency: a word accepted at edge N presents out_valid from the cycle after edge N. It completes at the first edge where out_ready[sel]=1.
- With out_ready[sel] stuck low, the first redirect occurs STALL_MAX+1 SEND cycles after the accept. Subsequent redirects follow every STALL_MAX+1 cycles.
- in_ready is combinational from en, state and out_ready. out_valid, out_data and sel are registered.
- out_valid is never asserted on more than one bit.

## Structure
- Shared package demux_pkg holds:
  - typedef enum state_t {IDLE, SEND}
  - typedef logic [1:0] dest_t
  - function dest_dec(dest_t) returning logic [3:0] one-hot
- Natural sub-module: dispatch_valid_demux. It is a 1-to-4 demux of the internal valid bit by sel, producing out_valid.
- Datapath is one W-bit holding register and is not replicated per destination.

## Test plan
- Reset with en=1: out_valid=0, sel=0, busy=0, in_ready=1. Assert rst_n=0 mid-SEND → out_valid=0 asynchronously, and the word is never delivered.
- Round-robin streaming: mode=0, out_ready=4'b1111, 6 back-to-back words 0x10..0x15 → sel sequence 0,1,2,3,0,1, one word per cycle, in_ready constantly 1.
- Fixed mode: mode=1, cfg_sel=2, 3 words, out_ready=4'b0100 → out_valid=4'b0100 for all three. Change cfg_sel to 1 mid-SEND → the held word still goes to 2.
- Backpressure: mode=0, out_ready[0]=0 for 5 cycles with STALL_MAX=15 → word 0xA5 held, in_ready=0, then delivered to 0 when ready rises. rr_ptr=1 after.
- Redirect: STALL_MAX=3, out_ready=4'b1110, word 0x5A to dest 0 → after 4 stall cycles sel=1, delivered at dest 1, next word goes to dest 2. Same stimulus with mode=1 → no redirect.
- en dropped during SEND → held word completes, and in_ready stays 0 until en=1.
